// File: rtl/pll_rst_seq.sv
// PLL reset / lock-qualify / ordered domain-release sequencer, clocked by the free-running reference.
// All outputs registered; pll_locked_i sees 2 cycles of synchronizer latency. No backpressure.
module pll_rst_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int SEQ_GAP      = 8,
    parameter int N_DOM        = 2,
    parameter int MAX_RETRY    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pll_locked_i,
    output logic             pll_rst_o,
    output logic [N_DOM-1:0] dom_rst_n_o,
    output logic             ready_o,
    output logic             fault_o,
    output logic [7:0]       retry_cnt_o
);

    localparam int MAX_AB = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > SEQ_GAP) ? LOCK_STABLE : SEQ_GAP;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int IW     = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [1:0]      lock_sync;
    logic            locked_s;
    logic [7:0]      retry_inc;
    logic            give_up;
    logic            fail_now;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked_i};
        end
    end

    assign locked_s  = lock_sync[1];
    assign retry_inc = (retry_cnt_o == 8'hFF) ? 8'hFF : retry_cnt_o + 8'd1;
    assign give_up   = (MAX_RETRY != 0) && (32'(retry_inc) >= 32'(MAX_RETRY));

    // Lock always beats the timeout; any locked_s=0 cycle once domains are releasing is a failure.
    assign fail_now = ((state == WAIT_LOCK) && !locked_s && (cnt == CW'(LOCK_TIMEOUT - 1)))
                   || (((state == RELEASE) || (state == RUN)) && !locked_s);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            ready_o     <= 1'b0;
            fault_o     <= 1'b0;
            retry_cnt_o <= 8'd0;
        end else if (fail_now) begin
            retry_cnt_o <= retry_inc;
            cnt         <= '0;
            idx         <= '0;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            ready_o     <= 1'b0;
            fault_o     <= give_up;
            state       <= give_up ? FAULT : HOLD;
        end else begin
            case (state)
                HOLD: begin
                    pll_rst_o   <= 1'b1;
                    dom_rst_n_o <= '0;
                    ready_o     <= 1'b0;
                    if (cnt == CW'(PLL_RST_CYC - 1)) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                WAIT_LOCK: begin
                    // The cycle that first sees lock counts toward LOCK_STABLE.
                    if (locked_s) begin
                        cnt <= '0;
                        if (LOCK_STABLE == 1) begin
                            state       <= RELEASE;
                            idx         <= '0;
                            dom_rst_n_o <= N_DOM'(1);
                        end else begin
                            state <= STABLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_STABLE - 2)) begin
                        state       <= RELEASE;
                        cnt         <= '0;
                        idx         <= '0;
                        dom_rst_n_o <= N_DOM'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RELEASE: begin
                    if (cnt == CW'(SEQ_GAP - 1)) begin
                        cnt <= '0;
                        if (idx == IW'(N_DOM - 1)) begin
                            state   <= RUN;
                            ready_o <= 1'b1;
                        end else begin
                            idx         <= idx + IW'(1);
                            dom_rst_n_o <= (dom_rst_n_o << 1) | N_DOM'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RUN: begin
                    ready_o <= 1'b1;
                end

                FAULT: begin
                    pll_rst_o   <= 1'b1;
                    dom_rst_n_o <= '0;
                    ready_o     <= 1'b0;
                    fault_o     <= 1'b1;
                end

                default: begin
                    state       <= HOLD;
                    cnt         <= '0;
                    idx         <= '0;
                    pll_rst_o   <= 1'b1;
                    dom_rst_n_o <= '0;
                    ready_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed sequence for pll_rst_seq; expected output vectors are queued per cycle and checked on negedge.
module tb_pll_rst_seq;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       pll_rst;
    logic [1:0] dom;
    logic       ready;
    logic       fault;
    logic [7:0] retry;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] vec;
    } exp_t;

    exp_t sb[$];

    pll_rst_seq #(
        .PLL_RST_CYC (4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (8),
        .SEQ_GAP     (4),
        .N_DOM       (2),
        .MAX_RETRY   (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pll_locked_i(lock),
        .pll_rst_o   (pll_rst),
        .dom_rst_n_o (dom),
        .ready_o     (ready),
        .fault_o     (fault),
        .retry_cnt_o (retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Vector layout: {pll_rst, dom[1:0], ready, fault, retry[7:0]}
    always @(negedge clk) begin
        int   i;
        exp_t e;
        logic [12:0] obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                e = sb[i];
                sb.delete(i);
                obs = {pll_rst, dom, ready, fault, retry};
                checks++;
                assert ((e.cyc == cyc) && (obs === e.vec)) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%h expected=%h (due cyc %0d)",
                           e.tag, cyc, obs, e.vec, e.cyc);
                end
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int c, input string t, input logic p, input logic [1:0] d,
                             input logic r, input logic f, input logic [7:0] rc);
        exp_t e;
        e.cyc = c;
        e.tag = t;
        e.vec = {p, d, r, f, rc};
        sb.push_back(e);
    endtask

    task automatic step_to(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    initial begin
        rst  = 1'b1;
        lock = 1'b0;

        // Nominal bring-up
        step_to(3);
        expect_at(3, "reset_vals", 1, 2'b00, 0, 0, 8'd0);
        rst = 1'b0;
        expect_at(6,  "nom_pll_hi", 1, 2'b00, 0, 0, 8'd0);
        expect_at(7,  "nom_pll_lo", 0, 2'b00, 0, 0, 8'd0);
        step_to(13);
        lock = 1'b1;
        expect_at(22, "nom_d0_pre", 0, 2'b00, 0, 0, 8'd0);
        expect_at(23, "nom_d0",     0, 2'b01, 0, 0, 8'd0);
        expect_at(26, "nom_d1_pre", 0, 2'b01, 0, 0, 8'd0);
        expect_at(27, "nom_d1",     0, 2'b11, 0, 0, 8'd0);
        expect_at(30, "nom_rdy_pre",0, 2'b11, 0, 0, 8'd0);
        expect_at(31, "nom_ready",  0, 2'b11, 1, 0, 8'd0);

        // Lock loss in RUN, then recovery
        step_to(35);
        lock = 1'b0;
        expect_at(37, "loss_pre",   0, 2'b11, 1, 0, 8'd0);
        expect_at(38, "loss",       1, 2'b00, 0, 0, 8'd1);
        expect_at(41, "loss_hold",  1, 2'b00, 0, 0, 8'd1);
        expect_at(42, "loss_wait",  0, 2'b00, 0, 0, 8'd1);
        step_to(45);
        lock = 1'b1;
        expect_at(54, "rec_d0_pre", 0, 2'b00, 0, 0, 8'd1);
        expect_at(55, "rec_d0",     0, 2'b01, 0, 0, 8'd1);
        expect_at(59, "rec_d1",     0, 2'b11, 0, 0, 8'd1);
        expect_at(62, "rec_rdy_pre",0, 2'b11, 0, 0, 8'd1);
        expect_at(63, "rec_ready",  0, 2'b11, 1, 0, 8'd1);

        // Timeout retry
        step_to(66);
        rst  = 1'b1;
        lock = 1'b0;
        expect_at(67, "rst_pulse",  1, 2'b00, 0, 0, 8'd0);
        step_to(67);
        rst = 1'b0;
        expect_at(70,  "to_hold",   1, 2'b00, 0, 0, 8'd0);
        expect_at(71,  "to_wait",   0, 2'b00, 0, 0, 8'd0);
        expect_at(102, "to_pre",    0, 2'b00, 0, 0, 8'd0);
        expect_at(103, "to_fail",   1, 2'b00, 0, 0, 8'd1);
        expect_at(106, "to_rehold", 1, 2'b00, 0, 0, 8'd1);
        expect_at(107, "to_rewait", 0, 2'b00, 0, 0, 8'd1);
        step_to(107);
        lock = 1'b1;
        expect_at(116, "to_d0_pre", 0, 2'b00, 0, 0, 8'd1);
        expect_at(117, "to_d0",     0, 2'b01, 0, 0, 8'd1);
        expect_at(125, "to_ready",  0, 2'b11, 1, 0, 8'd1);

        // Unstable lock: 5 high, 1 low, high again
        step_to(128);
        rst  = 1'b1;
        lock = 1'b0;
        expect_at(129, "us_reset",  1, 2'b00, 0, 0, 8'd0);
        step_to(129);
        rst = 1'b0;
        step_to(135);
        lock = 1'b1;
        step_to(140);
        lock = 1'b0;
        step_to(141);
        lock = 1'b1;
        expect_at(145, "us_no_rel", 0, 2'b00, 0, 0, 8'd0);
        expect_at(150, "us_d0_pre", 0, 2'b00, 0, 0, 8'd0);
        expect_at(151, "us_d0",     0, 2'b01, 0, 0, 8'd0);
        expect_at(153, "us_d0_hold",0, 2'b01, 0, 0, 8'd0);

        // Reset between dom[0] and dom[1] releases; lock stays high
        step_to(153);
        rst = 1'b1;
        expect_at(154, "mid_rst",   1, 2'b00, 0, 0, 8'd0);
        step_to(154);
        rst = 1'b0;
        expect_at(155, "mid_no_d1", 1, 2'b00, 0, 0, 8'd0);
        expect_at(157, "mid_hold",  1, 2'b00, 0, 0, 8'd0);
        expect_at(158, "mid_wait",  0, 2'b00, 0, 0, 8'd0);
        expect_at(165, "mid_d0_pre",0, 2'b00, 0, 0, 8'd0);
        expect_at(166, "mid_d0",    0, 2'b01, 0, 0, 8'd0);
        expect_at(170, "mid_d1",    0, 2'b11, 0, 0, 8'd0);
        expect_at(174, "mid_ready", 0, 2'b11, 1, 0, 8'd0);

        // Fault after three timeouts
        step_to(176);
        rst  = 1'b1;
        lock = 1'b0;
        expect_at(177, "f_reset",   1, 2'b00, 0, 0, 8'd0);
        step_to(177);
        rst = 1'b0;
        expect_at(212, "f_to1_pre", 0, 2'b00, 0, 0, 8'd0);
        expect_at(213, "f_to1",     1, 2'b00, 0, 0, 8'd1);
        expect_at(249, "f_to2",     1, 2'b00, 0, 0, 8'd2);
        expect_at(284, "f_to3_pre", 0, 2'b00, 0, 0, 8'd2);
        expect_at(285, "f_fault",   1, 2'b00, 0, 1, 8'd3);
        step_to(290);
        lock = 1'b1;
        expect_at(295, "f_sticky1", 1, 2'b00, 0, 1, 8'd3);
        step_to(300);
        lock = 1'b0;
        step_to(305);
        lock = 1'b1;
        expect_at(310, "f_sticky2", 1, 2'b00, 0, 1, 8'd3);
        step_to(320);
        rst = 1'b1;
        expect_at(321, "f_clear",   1, 2'b00, 0, 0, 8'd0);
        step_to(321);
        rst = 1'b0;
        expect_at(324, "f_rehold",  1, 2'b00, 0, 0, 8'd0);
        expect_at(325, "f_rewait",  0, 2'b00, 0, 0, 8'd0);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
